// File: rtl/updown_counter_param_pkg.sv
// Shared direction/mode encodings for the parametrised up/down counter.
// Both encodings are single-bit, so a port value casts directly to the enum.
package updown_counter_param_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/updown_counter_param_count_prescaler.sv
// Clock-enable prescaler for the up/down counter.
// tick is high while the count sits on the PRESCALE-th enabled cycle.
module count_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, clr, en, sync_clr};
            assign tick     = 1'b1;
        end else begin : g_div
            localparam int CW = $clog2(PRESCALE);
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] r_cnt;

            // The phase only advances on enabled cycles, so en=0 freezes it mid-period.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_cnt <= '0;
                end else if (sync_clr) begin
                    r_cnt <= '0;
                end else if (en) begin
                    r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
                end
            end

            assign tick = (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: modulus, parallel load, wrap/saturate,
// optional prescaler, registered terminal-count pulse and sticky flags.
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             m,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    // MODULUS may equal 2**WIDTH, so the load clamp compares one bit wider.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_q_next;
    logic             w_tc_next;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_tick;
    logic             w_step;
    dir_e             w_dir;
    mode_e            w_mode;

    count_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .sync_clr (load),
        .tick     (w_tick)
    );

    assign w_dir      = dir_e'(m);
    assign w_mode     = mode_e'(sat ^ SATURATE[0]);
    assign w_load_val = ({1'b0, d} >= MOD_EXT) ? MAX_Q : d;
    assign w_step     = en & w_tick & ~load;

    always_comb begin
        w_q_next  = r_q;
        w_tc_next = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (load) begin
            w_q_next = w_load_val;
        end else if (w_step) begin
            if (w_dir == DIR_UP) begin
                if (r_q == MAX_Q) begin
                    w_ovf_set = 1'b1;
                    w_tc_next = 1'b1;
                    if (w_mode == MODE_WRAP) w_q_next = '0;
                end else begin
                    w_q_next = r_q + WIDTH'(1);
                end
            end else begin
                if (r_q == '0) begin
                    w_unf_set = 1'b1;
                    w_tc_next = 1'b1;
                    if (w_mode == MODE_WRAP) w_q_next = MAX_Q;
                end else begin
                    w_q_next = r_q - WIDTH'(1);
                end
            end
        end
    end

    // A boundary step in the same cycle as flag_clr leaves the flag set.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_tc  <= w_tc_next;
            r_ovf <= w_ovf_set | (r_ovf & ~flag_clr);
            r_unf <= w_unf_set | (r_unf & ~flag_clr);
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign ovf = r_ovf;
    assign unf = r_unf;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three parameterisations share one stimulus
// stream and are checked every cycle against an integer model of the counter.
module tb_updown_counter_param;

  localparam int N = 3;
  // dut0: defaults, dut1: MODULUS=6, dut2: PRESCALE=3
  int mod_p[N] = '{8, 6, 8};
  int pre_p[N] = '{1, 1, 3};

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic       m = 1'b0;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [2:0] d = 3'd0;
  logic       flag_clr = 1'b0;

  logic [2:0] q0, q1, q2;
  logic       tc0, tc1, tc2, ovf0, ovf1, ovf2, unf0, unf1, unf2;

  int  chk_cnt = 0;
  int  pass_cnt = 0;
  bit  chk_en = 1'b0;

  int  mq[N], mpc[N], mtc[N], movf[N], munf[N];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(3), .MODULUS(8), .PRESCALE(1), .SATURATE(0)) u_dut0 (
    .clk(clk), .clr(clr), .en(en), .m(m), .sat(sat), .load(load), .d(d),
    .flag_clr(flag_clr), .q(q0), .tc(tc0), .ovf(ovf0), .unf(unf0));
  updown_counter_param #(.WIDTH(3), .MODULUS(6), .PRESCALE(1), .SATURATE(0)) u_dut1 (
    .clk(clk), .clr(clr), .en(en), .m(m), .sat(sat), .load(load), .d(d),
    .flag_clr(flag_clr), .q(q1), .tc(tc1), .ovf(ovf1), .unf(unf1));
  updown_counter_param #(.WIDTH(3), .MODULUS(8), .PRESCALE(3), .SATURATE(0)) u_dut2 (
    .clk(clk), .clr(clr), .en(en), .m(m), .sat(sat), .load(load), .d(d),
    .flag_clr(flag_clr), .q(q2), .tc(tc2), .ovf(ovf2), .unf(unf2));

  // ---------------- behavioural model ----------------
  always @(posedge clk or posedge clr) begin
    for (int k = 0; k < N; k++) begin
      if (clr) begin
        mq[k] = 0; mpc[k] = 0; mtc[k] = 0; movf[k] = 0; munf[k] = 0;
      end else begin
        bit stp;
        stp = 1'b0;
        mtc[k] = 0;
        if (flag_clr) begin
          movf[k] = 0;
          munf[k] = 0;
        end
        if (load) begin
          mq[k]  = (int'(d) >= mod_p[k]) ? mod_p[k] - 1 : int'(d);
          mpc[k] = 0;
        end else if (en) begin
          mpc[k] = mpc[k] + 1;
          if (mpc[k] == pre_p[k]) begin
            mpc[k] = 0;
            stp = 1'b1;
          end
        end
        if (stp && !m) begin
          if (mq[k] == mod_p[k] - 1) begin
            movf[k] = 1; mtc[k] = 1;
            if (!sat) mq[k] = 0;
          end else mq[k] = mq[k] + 1;
        end else if (stp && m) begin
          if (mq[k] == 0) begin
            munf[k] = 1; mtc[k] = 1;
            if (!sat) mq[k] = mod_p[k] - 1;
          end else mq[k] = mq[k] - 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0.q", int'(q0), mq[0]);   check("dut0.tc", int'(tc0), mtc[0]);
      check("dut0.ovf", int'(ovf0), movf[0]); check("dut0.unf", int'(unf0), munf[0]);
      check("dut1.q", int'(q1), mq[1]);   check("dut1.tc", int'(tc1), mtc[1]);
      check("dut1.ovf", int'(ovf1), movf[1]); check("dut1.unf", int'(unf1), munf[1]);
      check("dut2.q", int'(q2), mq[2]);   check("dut2.tc", int'(tc2), mtc[2]);
      check("dut2.ovf", int'(ovf2), movf[2]); check("dut2.unf", int'(unf2), munf[2]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [2:0] v, input logic with_en);
    load = 1'b1; d = v; en = with_en;
    cyc(1);
    load = 1'b0; en = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    cyc(2);
    check("reset.q0", int'(q0), 0);
    check("reset.tc0", int'(tc0), 0);
    clr = 1'b0;
    chk_en = 1'b1;

    // 1: up wrap on defaults
    en = 1'b1; m = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cyc(1);
      check("t1.q0", int'(q0), i % 8);
      if (i == 8) begin
        check("t1.tc0_wrap", int'(tc0), 1);
        check("t1.ovf0", int'(ovf0), 1);
      end
      if (i == 9) check("t1.tc0_after", int'(tc0), 0);
    end
    en = 1'b0;

    // 2: down wrap, then flag clear
    do_load(3'd0, 1'b0);
    en = 1'b1; m = 1'b1;
    cyc(1);
    check("t2.q0_wrap", int'(q0), 7);
    check("t2.tc0", int'(tc0), 1);
    check("t2.unf0", int'(unf0), 1);
    cyc(1); check("t2.q0_6", int'(q0), 6); check("t2.tc0_low", int'(tc0), 0);
    cyc(1); check("t2.q0_5", int'(q0), 5);
    en = 1'b0; flag_clr = 1'b1;
    cyc(1);
    flag_clr = 1'b0;
    check("t2.ovf0_clr", int'(ovf0), 0);
    check("t2.unf0_clr", int'(unf0), 0);

    // 3: saturate at MODULUS-1 on dut1
    sat = 1'b1;
    do_load(3'd4, 1'b0);
    en = 1'b1; m = 1'b0;
    cyc(1); check("t3.q1_a", int'(q1), 5); check("t3.tc1_a", int'(tc1), 0); check("t3.ovf1_a", int'(ovf1), 0);
    cyc(1); check("t3.q1_b", int'(q1), 5); check("t3.tc1_b", int'(tc1), 1); check("t3.ovf1_b", int'(ovf1), 1);
    cyc(1); check("t3.q1_c", int'(q1), 5); check("t3.tc1_c", int'(tc1), 1);
    en = 1'b0; sat = 1'b0;

    // 4: load clamp and load-over-enable priority
    do_load(3'd7, 1'b0);
    check("t4.q1_clamp", int'(q1), 5);
    check("t4.q0_noclamp", int'(q0), 7);
    do_load(3'd3, 1'b1);
    check("t4.q0_load_en", int'(q0), 3);
    check("t4.q1_load_en", int'(q1), 3);
    check("t4.tc0_load", int'(tc0), 0);

    // 5: prescaler phase on dut2
    do_load(3'd0, 1'b0);
    en = 1'b1; m = 1'b0;
    cyc(1); check("t5.q2_e1", int'(q2), 0);
    cyc(1); check("t5.q2_e2", int'(q2), 0);
    cyc(1); check("t5.q2_e3", int'(q2), 1);
    cyc(1);
    en = 1'b0; cyc(2); check("t5.q2_hold", int'(q2), 1);
    en = 1'b1;
    cyc(1); check("t5.q2_e5", int'(q2), 1);
    cyc(1); check("t5.q2_e6", int'(q2), 2);
    cyc(1);
    do_load(3'd5, 1'b1);
    en = 1'b1;
    cyc(2); check("t5.q2_phase_reset", int'(q2), 5);
    cyc(1); check("t5.q2_after_load", int'(q2), 6);
    en = 1'b0;

    // 6: asynchronous clear between edges
    do_load(3'd5, 1'b0);
    check("t6.q0_pre", int'(q0), 5);
    #2 clr = 1'b1;
    #1;
    check("t6.q0_async", int'(q0), 0);
    check("t6.q2_async", int'(q2), 0);
    check("t6.tc0_async", int'(tc0), 0);
    check("t6.ovf1_async", int'(ovf1), 0);
    cyc(1);
    clr = 1'b0; en = 1'b1; m = 1'b0;
    cyc(1); check("t6.q0_r1", int'(q0), 1); check("t6.q2_r1", int'(q2), 0);
    cyc(1); check("t6.q0_r2", int'(q0), 2); check("t6.q2_r2", int'(q2), 0);
    cyc(1); check("t6.q2_r3", int'(q2), 1);
    en = 1'b0;
    cyc(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
